// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the SRAM data-memory controller: FSM encoding,
// default address map base and half-word select constants.
package mem_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LO   = 2'd1;
  localparam state_t ST_HI   = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam int ADDR_BASE_DEF = 1024;

  localparam logic LO_HALF = 1'b0;
  localparam logic HI_HALF = 1'b1;

endpackage

// File: rtl/sram_wait_counter.sv
// Phase timer: reloads to ACCESS_CYCLES-1 on phase entry and counts down,
// flagging the final cycle of the phase with o_last.
module sram_wait_counter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_last
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CW'(ACCESS_CYCLES - 1);
    end else if (r_count != '0) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_last = (r_count == '0);

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage data memory controller: performs each 32-bit load/store as two
// timed half-word accesses (low half first) on an external 16-bit async SRAM.
module sram_mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_BASE     = ADDR_BASE_DEF,
  parameter int SRAM_ADDR_W   = 18,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n
);

  localparam int WW = SRAM_ADDR_W - 1;

  state_t                 r_state;
  logic                   r_is_write;
  logic [WW-1:0]          r_widx;
  logic [15:0]            r_wdata_hi;
  logic [31:0]            r_read_data;
  logic [SRAM_ADDR_W-1:0] r_sram_addr;
  logic [15:0]            r_dq_out;

  logic [31:0]   w_offset;
  logic [WW-1:0] w_widx;
  logic          w_req;
  logic          w_last;
  logic          w_load;
  logic          w_in_phase;

  // Word index wraps modulo the SRAM size by truncation.
  assign w_offset = address - 32'(ADDR_BASE);
  assign w_widx   = WW'(w_offset >> 2);
  assign w_req    = rd_en | wr_en;
  assign w_load   = ((r_state == ST_IDLE) && w_req) || ((r_state == ST_LO) && w_last);

  sram_wait_counter #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_load),
    .o_last(w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_is_write  <= 1'b0;
      r_widx      <= '0;
      r_wdata_hi  <= '0;
      r_read_data <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_state     <= ST_LO;
            r_is_write  <= wr_en;
            r_widx      <= w_widx;
            r_wdata_hi  <= write_data[31:16];
            r_sram_addr <= {w_widx, LO_HALF};
            if (wr_en) r_dq_out <= write_data[15:0];
          end
        end
        ST_LO: begin
          if (w_last) begin
            if (!r_is_write) r_read_data[15:0] <= sram_dq_in;
            r_state     <= ST_HI;
            r_sram_addr <= {r_widx, HI_HALF};
            if (r_is_write) r_dq_out <= r_wdata_hi;
          end
        end
        ST_HI: begin
          if (w_last) begin
            if (!r_is_write) r_read_data[31:16] <= sram_dq_in;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobe is released on the last cycle of each phase so data/address hold past the write edge.
  assign w_in_phase  = (r_state == ST_LO) || (r_state == ST_HI);
  assign sram_dq_oe  = r_is_write & w_in_phase;
  assign sram_we_n   = ~(sram_dq_oe & ~w_last);
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_dq_out;
  assign read_data   = r_read_data;
  assign ready       = ((r_state == ST_IDLE) && !w_req) || (r_state == ST_DONE);

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench for sram_mem_controller with a behavioural 16-bit SRAM;
// stimulus pushes expected transactions, a negedge monitor checks completions.
module tb_sram_mem_controller;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        isWrite;
    logic [31:0] expRead;
    logic [17:0] expAddr0;
    logic [15:0] expDq0;
    logic [15:0] expDq1;
  } expT;

  expT expQ[$];

  logic [15:0] sramMem [0:63];

  sram_mem_controller dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_we_n  (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb sram_dq_in = sramMem[sram_addr[5:0]];

  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) sramMem[sram_addr[5:0]] <= sram_dq_out;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: counts busy cycles, snapshots SRAM pins at the start/end of each phase.
  int          busyCnt = 0;
  logic [17:0] capAddr0, capAddr1;
  logic [15:0] capDq0, capDq1;
  logic        capOe0, capWe0, capWeLast0, capOe1, capWe1;

  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busyCnt = 0;
      end else if (rd_en || wr_en) begin
        if (!ready) begin
          busyCnt++;
          if (busyCnt == 2) begin
            capAddr0 = sram_addr; capDq0 = sram_dq_out; capOe0 = sram_dq_oe; capWe0 = sram_we_n;
          end
          if (busyCnt == 3) capWeLast0 = sram_we_n;
          if (busyCnt == 4) begin
            capAddr1 = sram_addr; capDq1 = sram_dq_out; capOe1 = sram_dq_oe; capWe1 = sram_we_n;
          end
        end else begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected completion: got one with empty scoreboard, expected none");
          end else begin
            e = expQ.pop_front();
            checkOutput("latency", 32'(busyCnt), 32'd5);
            checkOutput("read_data", read_data, e.expRead);
            checkOutput("addr lo", 32'(capAddr0), 32'(e.expAddr0));
            checkOutput("addr hi", 32'(capAddr1), 32'(e.expAddr0 + 18'd1));
            checkOutput("oe lo", 32'(capOe0), 32'(e.isWrite));
            checkOutput("oe hi", 32'(capOe1), 32'(e.isWrite));
            checkOutput("we_n lo", 32'(capWe0), 32'(!e.isWrite));
            checkOutput("we_n hi", 32'(capWe1), 32'(!e.isWrite));
            checkOutput("we_n lo last", 32'(capWeLast0), 32'd1);
            if (e.isWrite) begin
              checkOutput("dq lo", 32'(capDq0), 32'(e.expDq0));
              checkOutput("dq hi", 32'(capDq1), 32'(e.expDq1));
            end
          end
          busyCnt = 0;
        end
      end
    end
  end

  task automatic waitDone(input string name);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (ready) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout %s: ready stayed 0, expected 1 within 50 cycles", name);
    end
  endtask

  task automatic pushExp(input logic isWr, input logic [31:0] data, input logic [31:0] expRead,
                         input logic [17:0] expAddr0);
    expT e;
    e.isWrite  = isWr;
    e.expRead  = expRead;
    e.expAddr0 = expAddr0;
    e.expDq0   = data[15:0];
    e.expDq1   = data[31:16];
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [31:0] expRead,
                               input logic [17:0] expAddr0, input string name);
    pushExp(wr, data, expRead, expAddr0);
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; address = addr; write_data = data;
    waitDone(name);
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) sramMem[i] = 16'hA000 + 16'(i);
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("reset ready", 32'(ready), 32'd1);
    checkOutput("reset read_data", read_data, 32'h0);
    checkOutput("reset we_n", 32'(sram_we_n), 32'd1);
    checkOutput("reset oe", 32'(sram_dq_oe), 32'd0);
    checkOutput("reset sram_addr", 32'(sram_addr), 32'd0);

    applyStimulus(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0, 18'd0, "store 1024");
    applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 18'd0, "load 1024");
    applyStimulus(1'b1, 1'b0, 32'd1032, 32'h0, 32'hA005A004, 18'd4, "load 1032");
    applyStimulus(1'b0, 1'b1, 32'd1036, 32'h55AA33CC, 32'hA005A004, 18'd6, "store 1036");
    applyStimulus(1'b1, 1'b1, 32'd1028, 32'h12345678, 32'hA005A004, 18'd2, "both 1028");
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0, 32'h12345678, 18'd2, "load 1028");
    applyStimulus(1'b1, 1'b0, 32'd525312, 32'h0, 32'hDEADBEEF, 18'd0, "load wrap");

    // Back-to-back: the request stays up through DONE, data changes in the gap cycle.
    pushExp(1'b1, 32'hCAFEF00D, 32'hDEADBEEF, 18'd8);
    pushExp(1'b1, 32'h0BADF00D, 32'hDEADBEEF, 18'd8);
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
    waitDone("b2b first");
    @(posedge clk); #1;
    write_data = 32'h0BADF00D;
    @(negedge clk);
    checkOutput("b2b gap ready", 32'(ready), 32'd0);
    waitDone("b2b second");
    @(posedge clk); #1;
    wr_en = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'd1040, 32'h0, 32'h0BADF00D, 18'd8, "load 1040");

    // Reset mid-write, in the first HI cycle.
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1044; write_data = 32'h11112222;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("midwr we_n", 32'(sram_we_n), 32'd0);
    checkOutput("midwr addr", 32'(sram_addr), 32'd11);
    checkOutput("midwr dq", 32'(sram_dq_out), 32'h1111);
    rst = 1'b1; wr_en = 1'b0;
    #1;
    checkOutput("abort we_n", 32'(sram_we_n), 32'd1);
    checkOutput("abort oe", 32'(sram_dq_oe), 32'd0);
    checkOutput("abort read_data", read_data, 32'h0);
    checkOutput("abort sram_addr", 32'(sram_addr), 32'd0);
    checkOutput("abort ready", 32'(ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post reset ready", 32'(ready), 32'd1);

    checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
